// File: rtl/uart_rx.sv
// Purpose: UART receiver; 2-flop line synchronizer, free-running 16x tick divider, start/data/stop FSM.
// Latency: done/error strobe about (8 + 16*NB_DATA + SB_TICK) ticks after the start edge, plus sync and output register.
// Backpressure: none; each frame result is a one-cycle strobe and o_rx_data holds the last good byte.
module uart_rx #(
  parameter int NB_DATA  = 8,
  parameter int SB_TICK  = 16,
  parameter int TICK_DIV = 326,
  parameter int NB_TICK  = 9
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
  output logic               o_frame_error
);

  // n counts 0..NB_DATA-1; s_cnt must reach both 15 (data bits) and SB_TICK-1 (stop bit).
  localparam int NB_N  = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int NB_S  = $clog2(S_MAX);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic               rx_meta_q, rx_s_q;
  logic [NB_TICK-1:0] tick_cnt_q;
  logic               tick;

  state_t             state_q, state_d;
  logic [NB_S-1:0]    s_cnt_q, s_cnt_d;
  logic [NB_N-1:0]    n_q, n_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               done_q, done_d;
  logic               ferr_q, ferr_d;

  // Two-flop synchronizer; flops reset to the idle (high) line level.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Free-running oversampling divider; the FSM never restarts it, so start detection has one tick of phase jitter.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + NB_TICK'(1);
    end
  end

  assign tick = (tick_cnt_q == NB_TICK'(TICK_DIV - 1));

  // FSM state, counters, shift register and registered output strobes.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_q     <= n_d;
      b_q     <= b_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: only IDLE->START may happen off a tick; bits are sampled near their centre.
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_d     = n_q;
    b_d     = b_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_cnt_q == NB_S'(7)) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_d     = '0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state_d = IDLE;
              s_cnt_d = '0;
            end
          end else begin
            s_cnt_d = s_cnt_q + NB_S'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_cnt_q == NB_S'(15)) begin
            s_cnt_d = '0;
            b_d     = {rx_s_q, b_q[NB_DATA-1:1]};
            if (n_q == NB_N'(NB_DATA - 1)) begin
              state_d = STOP;
            end else begin
              n_d = n_q + NB_N'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + NB_S'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_cnt_q == NB_S'(SB_TICK - 1)) begin
            if (rx_s_q) begin
              data_d = b_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
            state_d = IDLE;
            s_cnt_d = '0;
          end else begin
            s_cnt_d = s_cnt_q + NB_S'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        s_cnt_d = '0;
      end
    endcase
  end

  assign o_rx_data     = data_q;
  assign o_rx_done     = done_q;
  assign o_frame_error = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are driven at 64 clocks/bit; a frame-level model predicts
// one result (good byte or framing error) per driven frame, and a per-cycle checker
// compares the strobes, their arrival window and the held data against that model.
module tb_uart_rx;

  localparam int NB_DATA  = 8;
  localparam int SB_TICK  = 16;
  localparam int TICK_DIV = 4;
  localparam int NB_TICK  = 2;
  localparam int BIT_CLKS = 16 * TICK_DIV;
  // 152 ticks +/- 1 tick from the rx_s edge, plus 2 sync clocks and the output register.
  localparam int LAT_MIN  = (8 + 16 * NB_DATA + SB_TICK - 1) * TICK_DIV + 2;
  localparam int LAT_MAX  = (8 + 16 * NB_DATA + SB_TICK + 1) * TICK_DIV + 4;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       done;
  logic       ferr;

  uart_rx #(
    .NB_DATA (NB_DATA),
    .SB_TICK (SB_TICK),
    .TICK_DIV(TICK_DIV),
    .NB_TICK (NB_TICK)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_rx         (rx),
    .o_rx_data    (rx_data),
    .o_rx_done    (done),
    .o_frame_error(ferr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];
  logic [7:0] exp_data = 8'h00;
  bit         model_on = 1'b0;
  bit         prev_pulse = 1'b0;
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         last_done = -1;
  int         last_gap = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d (cycle %0d)", nm, act, lo, hi, cyc);
    end
  endtask

  // Per-cycle checker, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (model_on) begin
      chk("pulse_exclusive", int'(done & ferr), 0);
      chk("pulse_not_back_to_back", int'((done | ferr) & prev_pulse), 0);
      if (done || ferr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind_is_error", int'(ferr), int'(e.is_err));
          chk_range("pulse_latency", cyc - e.t, LAT_MIN, LAT_MAX);
          if (!e.is_err) exp_data = e.data;
        end
        if (done) begin
          done_cnt++;
          if (last_done >= 0) last_gap = cyc - last_done;
          last_done = cyc;
        end
        if (ferr) ferr_cnt++;
      end
      if (exp_q.size() > 0 && (cyc - exp_q[0].t) > LAT_MAX + 2) begin
        chk("pulse_arrived_in_window", 0, 1);
        void'(exp_q.pop_front());
      end
      chk("rx_data_hold", int'(rx_data), int'(exp_data));
      prev_pulse = done | ferr;
    end
  end

  // Hold the line at v for n clocks; always returns 1 time unit after a rising edge.
  task automatic line(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame. A bad stop bit is held low across its sample point and then
  // released early, so the receiver's immediate restart from IDLE is seen as a glitch.
  task automatic send(input logic [7:0] d, input bit stop_ok, input int gap);
    exp_t e;
    e.is_err = !stop_ok;
    e.data   = d;
    e.t      = cyc;
    exp_q.push_back(e);
    line(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) line(d[i], BIT_CLKS);
    if (stop_ok) begin
      line(1'b1, BIT_CLKS);
    end else begin
      line(1'b0, 40);
      line(1'b1, BIT_CLKS - 40);
    end
    if (gap > 0) line(1'b1, gap);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    bit         ok;
    int         gap;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_rx_done", int'(done), 0);
    chk("reset_frame_error", int'(ferr), 0);
    rst = 1'b0;
    model_on = 1'b1;

    // Idle line: nothing may happen.
    line(1'b1, 2000);
    chk("idle_pulses", done_cnt + ferr_cnt, 0);

    send(8'hA5, 1'b1, 100);
    chk("a5_data", int'(rx_data), 'hA5);
    chk("a5_done_cnt", done_cnt, 1);
    chk("a5_ferr_cnt", ferr_cnt, 0);

    send(8'h00, 1'b1, 0);
    send(8'hFF, 1'b1, 100);
    chk("b2b_data", int'(rx_data), 'hFF);
    chk("b2b_done_cnt", done_cnt, 3);
    chk_range("b2b_done_spacing", last_gap, 10 * BIT_CLKS - 4, 10 * BIT_CLKS + 4);

    line(1'b0, 16);
    line(1'b1, 100);
    chk("glitch_done_cnt", done_cnt, 3);
    chk("glitch_ferr_cnt", ferr_cnt, 0);

    send(8'h3C, 1'b1, 100);
    chk("3c_data", int'(rx_data), 'h3C);
    chk("3c_done_cnt", done_cnt, 4);

    send(8'h5A, 1'b0, 100);
    chk("badstop_ferr_cnt", ferr_cnt, 1);
    chk("badstop_done_cnt", done_cnt, 4);
    chk("badstop_data_kept", int'(rx_data), 'h3C);

    // Frame 0x81 aborted by reset after data bit 3.
    d = 8'h81;
    line(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) line(d[i], BIT_CLKS);
    rst = 1'b1;
    rx = 1'b1;
    exp_data = 8'h00;
    #1;
    chk("midreset_rx_data", int'(rx_data), 0);
    chk("midreset_rx_done", int'(done), 0);
    chk("midreset_frame_error", int'(ferr), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    line(1'b1, 700);
    chk("midreset_no_pulse", done_cnt + ferr_cnt, 5);

    send(8'h81, 1'b1, 100);
    chk("81_data", int'(rx_data), 'h81);
    chk("81_done_cnt", done_cnt, 5);

    // Random frames, random idle gaps (so random tick phase), occasional bad stop bits.
    for (int k = 0; k < 16; k++) begin
      d   = 8'($urandom_range(255));
      ok  = ($urandom_range(4) != 0);
      gap = ok ? int'($urandom_range(40)) : 64 + int'($urandom_range(40));
      send(d, ok, gap);
    end

    line(1'b1, 800);
    chk("all_frames_reported", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
